// File: rtl/substraction_core_pkg.sv
// Shared constants and types for the registered subtractor.
// Holds the default operand width and the packed layout of the status flags.
package substraction_core_pkg;

   localparam int unsigned SUB_DEFAULT_WIDTH = 32'd4;

   // Status flags captured on the same edge as the difference
   typedef struct packed {
      logic borrow;
      logic zero;
   } sub_flags_t;

endpackage

// File: rtl/substraction_core_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with bout set on underflow.
// The cells are chained bit by bit into a ripple-borrow subtractor.
module substraction_core_full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic diff_xy_s;

   assign diff_xy_s = x ^ y;
   assign d         = diff_xy_s ^ bin;
   // A borrow is generated when y beats x, or propagated when x equals y
   assign bout      = (~x & y) | (~diff_xy_s & bin);

endmodule

// File: rtl/substraction_core.sv
// Registered WIDTH-bit unsigned subtractor: result = a - b mod 2^WIDTH,
// with borrow (a < b) and zero (a == b) flags, all launched from flops.
module substraction_core
   import substraction_core_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             borrow,
   output logic             zero
);

   logic [WIDTH:0]   borrow_chain_s;
   logic [WIDTH-1:0] diff_s;
   sub_flags_t       flags_s;
   logic [WIDTH-1:0] result_r;
   sub_flags_t       flags_r;

   assign borrow_chain_s[0] = 1'b0;

   // The borrow ripples from bit 0 up; the final borrow-out is the underflow flag
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         substraction_core_full_subtractor u_fs (
            .x    (a[i]),
            .y    (b[i]),
            .bin  (borrow_chain_s[i]),
            .d    (diff_s[i]),
            .bout (borrow_chain_s[i+1])
         );
      end
   endgenerate

   // Flags come from the difference itself: a zero low word can only mean a == b
   always_comb begin
      flags_s        = sub_flags_t'(2'b00);
      flags_s.borrow = borrow_chain_s[WIDTH];
      flags_s.zero   = ~|diff_s;
   end

   // Output stage: difference and flags captured together, cleared asynchronously
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         result_r <= {WIDTH{1'b0}};
         flags_r  <= sub_flags_t'(2'b00);
      end else begin
         result_r <= diff_s;
         flags_r  <= flags_s;
      end
   end

   assign result = result_r;
   assign borrow = flags_r.borrow;
   assign zero   = flags_r.zero;

endmodule

// File: tb/tb_substraction_core.sv
// Self-checking bench for substraction_core (WIDTH = 4): directed boundary
// vectors, asynchronous reset cases and a randomized sweep against an integer model.
module tb_substraction_core;

   localparam int unsigned W = 4;

   logic         clk;
   logic         n_rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] result;
   logic         borrow;
   logic         zero;

   int checks_cnt;
   int fail_cnt;

   substraction_core #(.WIDTH(W)) dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .a      (a),
      .b      (b),
      .result (result),
      .borrow (borrow),
      .zero   (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain signed integer subtraction of the captured operands
   task automatic check_model(input string tag, input int av, input int bv);
      int d;
      d = av - bv;
      check_eq({tag, "_result"}, 32'(result), 32'((d + 16) % 16));
      check_eq({tag, "_borrow"}, 32'(borrow), (d < 0) ? 32'd1 : 32'd0);
      check_eq({tag, "_zero"},   32'(zero),   (d == 0) ? 32'd1 : 32'd0);
   endtask

   task automatic check_cleared(input string tag);
      check_eq({tag, "_result"}, 32'(result), 32'd0);
      check_eq({tag, "_borrow"}, 32'(borrow), 32'd0);
      check_eq({tag, "_zero"},   32'(zero),   32'd0);
   endtask

   task automatic run_vec(input string tag, input int av, input int bv);
      @(negedge clk);
      a = W'(av);
      b = W'(bv);
      @(posedge clk);
      #1;
      check_model(tag, av, bv);
   endtask

   initial begin
      checks_cnt = 0;
      fail_cnt   = 0;
      n_rst = 1'b1;
      a     = 4'd3;
      b     = 4'd1;
      #2;
      check_cleared("reset");
      #5;
      n_rst = 1'b0;
      @(posedge clk);
      #1;
      check_model("first", 3, 1);

      run_vec("five_two", 5, 2);
      // Inputs changing between edges must not disturb the held outputs
      @(negedge clk);
      a = 4'd12;
      b = 4'd6;
      #1;
      check_model("hold", 5, 2);
      @(posedge clk);
      #1;
      check_model("hold_next", 12, 6);

      run_vec("underflow", 1, 3);
      run_vec("equal", 7, 7);
      run_vec("zero_minus_max", 0, 15);
      run_vec("max_minus_zero", 15, 0);
      run_vec("zero_zero", 0, 0);
      run_vec("max_max", 15, 15);
      run_vec("one_minus_max", 1, 15);

      // Reset between edges while the result is nonzero
      run_vec("pre_reset", 0, 15);
      @(negedge clk);
      n_rst = 1'b1;
      a = 4'd9;
      b = 4'd4;
      #1;
      check_cleared("async_reset");
      @(posedge clk);
      #1;
      check_cleared("reset_held");
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      check_cleared("released");
      @(posedge clk);
      #1;
      check_model("after_reset", 9, 4);

      // Reset while the zero flag is set
      run_vec("pre_reset_zero", 6, 6);
      @(negedge clk);
      n_rst = 1'b1;
      #1;
      check_cleared("async_reset_zero");
      @(negedge clk);
      n_rst = 1'b0;

      for (int i = 0; i < 1000; i++) begin
         int ra;
         int rb;
         ra = int'($urandom_range(0, 15));
         rb = ((i % 8) == 0) ? ra : int'($urandom_range(0, 15));
         run_vec("random", ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
